// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Conditions n raw board switches into a clean, registered value for the cpu.
// Each bit is synchronised through two flops, then accepted only after the
// synchronised value has disagreed with the current output for DB_CYCLES
// further consecutive enabled cycles. Bit n-1 additionally produces
// one-cycle rise/fall pulses when its accepted value changes.
//
// Ports
//   Clock    : system clock, rising-edge active
//   nReset   : asynchronous active-low reset
//   SwRaw    : raw, asynchronous, bouncing switch inputs [n-1:0]
//   Enable   : 1 = debounce runs, 0 = outputs freeze, all bits forced idle
//   SW       : debounced, synchronised switch value [n-1:0] (registered)
//   Sw8Rise  : one-cycle pulse after SW[n-1] is accepted 0->1 (registered)
//   Sw8Fall  : one-cycle pulse after SW[n-1] is accepted 1->0 (registered)
// ---------------------------------------------------------------------------
module switch_debounce #(
    parameter int n         = 9,
    parameter int DB_CYCLES = 16
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic [n-1:0] SwRaw,
    input  logic         Enable,
    output logic [n-1:0] SW,
    output logic         Sw8Rise,
    output logic         Sw8Fall
);

    // Counter only ever reaches DB_CYCLES-1, so ceil(log2(DB_CYCLES)) bits suffice.
    localparam int             CW       = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    logic [n-1:0] sync1_r;
    logic [n-1:0] sync2_r;
    logic [n-1:0] sw_r;
    logic         rise_r;
    logic         fall_r;
    logic [n-1:0] diff_s;
    logic [n-1:0] accept_s;

    // Two-flop synchroniser; the only logic that samples SwRaw. Keeps running
    // regardless of Enable so the value is settled when debouncing resumes.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= SwRaw;
            sync2_r <= sync1_r;
        end
    end

    assign diff_s = sync2_r ^ sw_r;

    for (genvar i = 0; i < n; i++) begin : g_bit
        state_t        state_r;
        logic [CW-1:0] cnt_r;

        // Acceptance needs Enable high so a falling Enable wins over a
        // count that would complete on the same edge.
        assign accept_s[i] = Enable && (state_r == COUNT) && diff_s[i] && (cnt_r == CNT_LAST);

        // Per-bit debounce FSM with its stability counter.
        always_ff @(posedge Clock or negedge nReset) begin
            if (!nReset) begin
                state_r <= IDLE;
                cnt_r   <= '0;
            end else if (!Enable) begin
                state_r <= IDLE;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        cnt_r   <= '0;
                        state_r <= diff_s[i] ? COUNT : IDLE;
                    end
                    COUNT: begin
                        if (!diff_s[i]) begin
                            // Input bounced back: abandon the count.
                            state_r <= IDLE;
                            cnt_r   <= '0;
                        end else if (cnt_r == CNT_LAST) begin
                            // Value accepted this edge; counter clears, never wraps.
                            state_r <= IDLE;
                            cnt_r   <= '0;
                        end else begin
                            state_r <= COUNT;
                            cnt_r   <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    // Output register plus edge pulses for the top bit. accept_s is already
    // gated by Enable, so with Enable low SW holds and both pulses drop to 0.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sw_r   <= '0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sw_r   <= (sw_r & ~accept_s) | (sync2_r & accept_s);
            rise_r <= accept_s[n-1] &  sync2_r[n-1];
            fall_r <= accept_s[n-1] & ~sync2_r[n-1];
        end
    end

    assign SW      = sw_r;
    assign Sw8Rise = rise_r;
    assign Sw8Fall = fall_r;

endmodule
